// File: rtl/router_pkg.sv
// router_pkg: mesh geometry, flit width and port-direction helpers shared by the link fabric.
package router_pkg;
    localparam int MAX_X           = 3;
    localparam int MAX_Y           = 3;
    localparam int NUM_PORTS       = 5;
    localparam int NOC_LINK_W      = 8;
    localparam int LINK_STAGES_DEF = 1;
    localparam int PORT_N          = 0;
    localparam int PORT_E          = 1;
    localparam int PORT_S          = 2;
    localparam int PORT_W          = 3;

    function automatic int opposite(input int p);
        return (p + 2) % 4;
    endfunction
endpackage

// File: rtl/link_pipe.sv
// link_pipe: STAGES-deep valid/data delay; data stages load only on valid, STAGES=0 is a wire.
module link_pipe #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);
    if (STAGES == 0) begin : g_comb
        logic w_unused_clk;
        assign w_unused_clk = clk ^ rst_n;
        assign out_valid    = in_valid;
        assign out_data     = in_data;
    end else begin : g_reg
        logic [STAGES-1:0] r_valid;
        logic [WIDTH-1:0]  r_data [STAGES];
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_valid <= '0;
                for (int i = 0; i < STAGES; i++) r_data[i] <= '0;
            end else begin
                r_valid[0] <= in_valid;
                if (in_valid) r_data[0] <= in_data;
                for (int i = 1; i < STAGES; i++) begin
                    r_valid[i] <= r_valid[i-1];
                    if (r_valid[i-1]) r_data[i] <= r_data[i-1];
                end
            end
        end
        assign out_valid = r_valid[STAGES-1];
        assign out_data  = r_data[STAGES-1];
    end
endmodule

// File: rtl/mesh_link_web.sv
// mesh_link_web: pipelined flit and credit wiring between neighbouring mesh routers, with edge checks.
// Define MESH_LINK_STATS_EN to build the saturating delivered-flit counter behind flit_cnt.
module mesh_link_web
    import router_pkg::*;
#(
    parameter int LINK_STAGES = LINK_STAGES_DEF
) (
    input  logic                                                         clk,
    input  logic                                                         rst_n,
    input  logic [MAX_X-1:0][MAX_Y-1:0][NUM_PORTS-2:0][NOC_LINK_W-1:0] outport_data,
    input  logic [MAX_X-1:0][MAX_Y-1:0][NUM_PORTS-2:0]                  outport_valid,
    output logic [MAX_X-1:0][MAX_Y-1:0][NUM_PORTS-2:0][NOC_LINK_W-1:0] inport_data,
    output logic [MAX_X-1:0][MAX_Y-1:0][NUM_PORTS-2:0]                  inport_valid,
    input  logic [MAX_X-1:0][MAX_Y-1:0][NUM_PORTS-2:0]                  credit_in,
    output logic [MAX_X-1:0][MAX_Y-1:0][NUM_PORTS-2:0]                  credit_out,
    input  logic                                                         edge_err_clr,
    output logic                                                         edge_err,
    input  logic                                                         stats_clr,
    output logic [31:0]                                                  flit_cnt
);
    localparam int NL = MAX_X * MAX_Y * (NUM_PORTS - 1);

    logic [NL-1:0] w_edge_viol;
    logic [NL-1:0] w_unused_drop;
    logic          r_edge_err;

    for (genvar x = 0; x < MAX_X; x++) begin : g_x
        for (genvar y = 0; y < MAX_Y; y++) begin : g_y
            for (genvar p = 0; p < NUM_PORTS - 1; p++) begin : g_p
                localparam int NX  = x + ((p == PORT_E) ? 1 : (p == PORT_W) ? -1 : 0);
                localparam int NY  = y + ((p == PORT_S) ? 1 : (p == PORT_N) ? -1 : 0);
                localparam int OP  = opposite(p);
                localparam int IDX = (x * MAX_Y + y) * (NUM_PORTS - 1) + p;
                if (NX >= 0 && NX < MAX_X && NY >= 0 && NY < MAX_Y) begin : g_link
                    logic w_cr_v;
                    logic w_cr_d;
                    link_pipe #(.WIDTH(NOC_LINK_W), .STAGES(LINK_STAGES)) u_data (
                        .clk       (clk),
                        .rst_n     (rst_n),
                        .in_valid  (outport_valid[x][y][p]),
                        .in_data   (outport_data[x][y][p]),
                        .out_valid (inport_valid[NX][NY][OP]),
                        .out_data  (inport_data[NX][NY][OP])
                    );
                    // Credit rides as both valid and data so the 1-bit data stage is not dead logic.
                    link_pipe #(.WIDTH(1), .STAGES(LINK_STAGES)) u_credit (
                        .clk       (clk),
                        .rst_n     (rst_n),
                        .in_valid  (credit_in[x][y][p]),
                        .in_data   (credit_in[x][y][p]),
                        .out_valid (w_cr_v),
                        .out_data  (w_cr_d)
                    );
                    assign credit_out[NX][NY][OP] = w_cr_v & w_cr_d;
                    assign w_edge_viol[IDX]       = 1'b0;
                    assign w_unused_drop[IDX]     = 1'b0;
                end else begin : g_edge
                    assign inport_valid[x][y][p] = 1'b0;
                    assign inport_data[x][y][p]  = '0;
                    assign credit_out[x][y][p]   = 1'b0;
                    assign w_edge_viol[IDX]      = outport_valid[x][y][p];
                    assign w_unused_drop[IDX]    = ^{outport_data[x][y][p], credit_in[x][y][p]};
                end
            end
        end
    end

    // A new violation overrides a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_edge_err <= 1'b0;
        else        r_edge_err <= (|w_edge_viol) | (r_edge_err & ~edge_err_clr);
    end
    assign edge_err = r_edge_err;

`ifdef MESH_LINK_STATS_EN
    logic [31:0] r_flit_cnt;
    logic [32:0] w_sum;
    assign w_sum = {1'b0, r_flit_cnt} + 33'($countones(inport_valid));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_flit_cnt <= '0;
        else        r_flit_cnt <= stats_clr ? '0 : (w_sum[32] ? '1 : w_sum[31:0]);
    end
    assign flit_cnt = r_flit_cnt;
`else
    logic w_unused_stats;
    assign w_unused_stats = stats_clr;
    assign flit_cnt       = '0;
`endif
endmodule

// File: doc/mesh_link_web.md
MESH_LINK_WEB -- requirements
Module: mesh_link_web

Interface
REQ-001 SHALL have parameter LINK_STAGES, default 1: register stages per link and per credit wire; legal range 0..4.
REQ-002 SHALL take MAX_X, MAX_Y, NUM_PORTS and NOC_LINK_W from router_pkg: mesh size, router ports (local port last), flit width.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port outport_data  input  [MAX_X][MAX_Y][NUM_PORTS-1] x NOC_LINK_W  flits leaving each router per mesh port.
REQ-006 SHALL have port outport_valid  input  [MAX_X][MAX_Y][NUM_PORTS-1] x 1  flit qualifier.
REQ-007 SHALL have port inport_data  output  [MAX_X][MAX_Y][NUM_PORTS-1] x NOC_LINK_W  flits arriving at each router.
REQ-008 SHALL have port inport_valid  output  [MAX_X][MAX_Y][NUM_PORTS-1] x 1  arrival qualifier.
REQ-009 SHALL have port credit_in  input  [MAX_X][MAX_Y][NUM_PORTS-1] x 1  credit returned by a receiving router per input port.
REQ-010 SHALL have port credit_out  output  [MAX_X][MAX_Y][NUM_PORTS-1] x 1  credit delivered to the sending router per output port.
REQ-011 SHALL have port edge_err_clr  input  1  clears edge_err.
REQ-012 SHALL have port edge_err  output  1  sticky: valid flit sent off-mesh.
REQ-013 SHALL have port stats_clr  input  1  clears flit_cnt.
REQ-014 SHALL have port flit_cnt  output  32  delivered-flit count.

Function
REQ-015 SHALL use port index 0=north (y-1), 1=east (x+1), 2=south (y+1), 3=west (x-1).
REQ-016 SHALL connect outport p of (x,y) to inport opposite(p) of the neighbour in direction p; opposite = (p+2) mod 4.
REQ-017 SHALL route credit_in[x][y][q] to credit_out of the neighbour in direction q, port opposite(q).
REQ-018 SHALL delay data, valid and credit by exactly LINK_STAGES cycles; LINK_STAGES=0 is a purely combinational path.
REQ-019 SHALL load a data stage only when its input valid is 1, hold data otherwise, and always propagate valid.
REQ-020 SHALL drive inport_data, inport_valid and credit_out to 0 on every edge-facing port, regardless of LINK_STAGES.
REQ-021 SHALL discard any flit or credit that a router drives on an edge-facing port.
REQ-022 SHALL set edge_err one cycle after any outport_valid=1 on an edge-facing port; it is sticky.
REQ-023 SHALL clear edge_err one cycle after edge_err_clr=1; when clear and a new violation occur in the same cycle, set wins.
REQ-024 SHALL add each cycle the number of inport_valid bits equal to 1 to flit_cnt, and saturate at 0xFFFF_FFFF with no wrap.
REQ-025 SHALL make flit_cnt read 0 on the cycle after stats_clr=1; clear takes priority over a same-cycle increment.

Reset
REQ-026 SHALL, while rst_n=0, clear all stage data, valid and credit registers, edge_err and flit_cnt to 0.
REQ-027 SHALL drop in-flight flits and credits when reset is asserted mid-operation; none reappear after reset release.

Configuration
REQ-028 SHALL, with macro MESH_LINK_STATS_EN defined, implement the flit_cnt counter per REQ-024/025.
REQ-029 SHALL, without MESH_LINK_STATS_EN, keep the stats_clr and flit_cnt ports, tie flit_cnt to constant 0 and build no counter logic.

Structure
REQ-030 SHALL place port index constants (PORT_N/E/S/W), the opposite-port function and the LINK_STAGES default in router_pkg.
REQ-031 SHALL implement each delay chain with one sub-module, link_pipe (parameters WIDTH, STAGES; ports clk, rst_n, in_valid, in_data, out_valid, out_data), instantiated per link and per credit wire.

Verification
REQ-032 SHALL check: 3x3 mesh, LINK_STAGES=2, (1,1) port 1 sends valid flit 0xA5 -> (2,1) port 3 gets valid=1, data=0xA5 exactly 2 cycles later.
REQ-033 SHALL check: LINK_STAGES=0, (0,0) port 2 sends 0x3C -> (0,1) port 0 gets 0x3C in the same cycle.
REQ-034 SHALL check: (0,0) port 3 sends valid flit -> edge_err=1 next cycle, all inports stay 0; edge_err_clr and a new violation in the same cycle -> edge_err stays 1.
REQ-035 SHALL check: (2,2) credit_in[0] pulses with LINK_STAGES=1 -> credit_out[2][1][2]=1 one cycle later.
REQ-036 SHALL check: rst_n low while 4 flits are in flight with LINK_STAGES=3 -> no inport_valid after release, flit_cnt=0.
REQ-037 SHALL check, with MESH_LINK_STATS_EN: flit_cnt preloaded to 0xFFFF_FFFE, 3 flits arrive in one cycle -> 0xFFFF_FFFF; stats_clr together with 1 arrival -> 0.
